pipe_hazard_ctrl: RTL and testbench

//  Hazard/stall sequencer for the 5-stage static pipeline. Drives the enable

---
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/stall sequencer for the 5-stage pipeline.
// Generates PC / pipeline-register enables and bubble/flush strobes from
// load-use, taken-branch and MDU-busy conditions, and times the multi-cycle
// mult/div unit with a down-counter.
// Optional feature: define PIPE_PERF_CNT_EN to add the stall_cycles counter
// (and its PERF_W parameter / output port).
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6
`ifdef PIPE_PERF_CNT_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic              ex_branch_taken,
  input  logic              id_mdu_start,
  input  logic              id_mdu_rd,
  output logic              pc_ena,
  output logic              ifid_ena,
  output logic              idex_ena,
  output logic              exmem_ena,
  output logic              memwb_ena,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              mdu_start,
  output logic              mdu_busy,
  output logic              mdu_done
`ifdef PIPE_PERF_CNT_EN
  , output logic [PERF_W-1:0] stall_cycles
`endif
);

  typedef enum logic {IDLE = 1'b0, MDU_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_d;
  logic              flush, lu_haz, mdu_haz, haz;

  // Hazard detection; flush wins over either stall source.
  always_comb begin
    flush   = ex_branch_taken;
    mdu_haz = mdu_busy & (id_mdu_rd | id_mdu_start);
    lu_haz  = ex_mem_read & (ex_rd != 5'd0) &
              ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
    haz     = ~flush & (mdu_haz | lu_haz);
  end

  // Enables and strobes; everything is forced quiet while reset is held.
  always_comb begin
    pc_ena     = ~rst & ~haz;
    ifid_ena   = ~rst & ~haz;
    idex_ena   = ~rst;
    exmem_ena  = ~rst;
    memwb_ena  = ~rst;
    ifid_flush = ~rst & flush;
    idex_flush = ~rst & (flush | haz);
    mdu_start  = id_mdu_start & ~mdu_busy & ~flush & ~lu_haz & ~rst;
  end

  assign mdu_busy = (state_q == MDU_RUN);

  // MDU sequencer next state: load counter on launch, count down, pulse done at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mdu_start) begin
          state_d = MDU_RUN;
          cnt_d   = CNT_W'(MDU_LAT - 1);
        end
      end
      MDU_RUN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MDU sequencer state; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mdu_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mdu_done <= done_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Stall cycle counter: one tick per cycle the PC is held (reset excluded).
  always_ff @(posedge clk) begin
    if (rst)          stall_cycles <= '0;
    else if (!pc_ena) stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with hand-computed expectations,
// MDU_LAT=4. Inputs change 1ns after the rising edge, outputs are sampled
// on the falling edge.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_mem_read, ex_branch_taken;
  logic       id_mdu_start, id_mdu_rd;
  logic       pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena;
  logic       ifid_flush, idex_flush, mdu_start, mdu_busy, mdu_done;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .id_mdu_start(id_mdu_start), .id_mdu_rd(id_mdu_rd),
    .pc_ena(pc_ena), .ifid_ena(ifid_ena), .idex_ena(idex_ena),
    .exmem_ena(exmem_ena), .memwb_ena(memwb_ena),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy), .mdu_done(mdu_done)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // advance to the next cycle and leave 1ns for hold
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rs = 0; id_use_rt = 0; ex_mem_read = 0; ex_branch_taken = 0;
    id_mdu_start = 0; id_mdu_rd = 0;
  endtask

  // hazard output triple {pc_ena, ifid_ena, idex_flush}
  function automatic logic [2:0] hz();
    return {pc_ena, ifid_ena, idex_flush};
  endfunction

  initial begin
    idle_in();
    rst = 1;
    id_mdu_start = 1;
    nxt(); nxt(); smp();
    chk("rst_ena", {pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena}, 5'b00000);
    chk("rst_flush", {ifid_flush, idex_flush}, 2'b00);
    chk("rst_start", mdu_start, 1'b0);
    chk("rst_mdu", {mdu_busy, mdu_done}, 2'b00);

    // ---- load-use ----
    nxt(); rst = 0; idle_in();
    smp(); chk("run_ena", {pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena}, 5'b11111);
    nxt(); ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
    smp(); chk("lu_rs", hz(), 3'b001);
    chk("lu_rs_down", {idex_ena, exmem_ena, memwb_ena, ifid_flush}, 4'b1110);
    nxt(); ex_mem_read = 0;             // bubble now in EX
    smp(); chk("lu_one_bubble", hz(), 3'b110);
    nxt(); ex_mem_read = 1; ex_rd = 0; id_rs = 0;
    smp(); chk("lu_r0", hz(), 3'b110);
    nxt(); ex_rd = 5; id_rs = 3; id_rt = 5; id_use_rs = 1; id_use_rt = 1;
    smp(); chk("lu_rt", hz(), 3'b001);
    nxt(); id_use_rt = 0;
    smp(); chk("lu_rt_unused", hz(), 3'b110);

    // ---- branch flush beats load-use ----
    nxt(); id_use_rt = 1; ex_branch_taken = 1;
    smp(); chk("br_flush", {pc_ena, ifid_ena, ifid_flush, idex_flush}, 4'b1111);
    nxt(); idle_in();

    // ---- MDU run with mfhi stall (c0..c6) ----
    rst = 1; nxt(); rst = 0;
    id_mdu_start = 1;                                 // c0
    smp(); chk("m_c0", {mdu_start, mdu_busy}, 2'b10);
    nxt(); id_mdu_start = 0;                          // c1
    smp(); chk("m_c1", {mdu_busy, pc_ena, mdu_done}, 3'b110);
    for (int c = 2; c <= 4; c++) begin
      nxt(); id_mdu_rd = 1;
      smp(); chk($sformatf("m_c%0d", c), {mdu_busy, mdu_done, hz()}, 5'b10001);
    end
    nxt();                                            // c5
    smp(); chk("m_c5", {mdu_busy, mdu_done, pc_ena}, 3'b011);
    nxt(); id_mdu_rd = 0;                             // c6
    smp(); chk("m_c6", {mdu_busy, mdu_done}, 2'b00);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_cnt", stall_cycles, 32'd3);
`endif

    // ---- back-to-back MDU ops ----
    nxt(); id_mdu_start = 1;                          // c0
    smp(); chk("b_c0", mdu_start, 1'b1);
    nxt(); id_mdu_start = 0;                          // c1
    for (int c = 2; c <= 4; c++) begin
      nxt(); id_mdu_start = 1;
      smp(); chk($sformatf("b_c%0d", c), {mdu_start, pc_ena, idex_flush}, 3'b001);
    end
    nxt();                                            // c5
    smp(); chk("b_c5", {mdu_start, pc_ena, mdu_done}, 3'b111);
    nxt(); id_mdu_start = 0;
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        smp(); if (mdu_done) seen = 1;
        if (!seen) nxt();
      end
      chk("b_drain", seen, 1'b1);
    end
    nxt();

    // ---- reset mid-run ----
    id_mdu_start = 1;                                 // c0
    smp(); chk("r_c0", mdu_start, 1'b1);
    nxt(); id_mdu_start = 0;                          // c1
    nxt(); rst = 1;                                   // c2
    smp(); chk("r_c2_ena", {pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena}, 5'b00000);
    nxt();                                            // c3
    smp(); chk("r_c3", {mdu_busy, mdu_done, pc_ena, memwb_ena}, 4'b0000);
    nxt(); rst = 0; id_mdu_rd = 1;
    for (int c = 4; c <= 8; c++) begin
      smp(); chk($sformatf("r_c%0d", c), {mdu_busy, mdu_done, hz()}, 5'b00110);
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

endmodule
